fetch_align_buffer: RTL and testbench

//  Sits between the combinational-read program memory and the decode stage. Fetches aligned 32-bit words.

---
 rtl/fetch_align_buffer.sv | 101 ++++++++++
 tb/tb_fetch_align_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_align_buffer.sv
// Fetch/align buffer: turns aligned 32-bit memory words into whole RV32I/RVC instructions for decode.
// Define FETCH_RVC_EN for RV32IC alignment; undefined builds pure RV32I (every instruction is 2 halfwords).
module fetch_align_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          BUF_HW   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_byte_address,
    input  logic [31:0] mem_read_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_compressed
);
    localparam int QW = BUF_HW * 16;
    localparam int CW = $clog2(BUF_HW + 1);

`ifdef FETCH_RVC_EN
    localparam bit RVC_EN = 1'b1;
`else
    localparam bit RVC_EN = 1'b0;
`endif

    // Without RVC, bit 1 of any PC is meaningless and forced to zero.
    localparam logic [31:0] RST_PC = RVC_EN ? RESET_PC : {RESET_PC[31:2], 2'b00};

    logic [31:0]   fetch_ptr;
    logic [31:0]   head_pc;
    logic [QW-1:0] q;
    logic [CW-1:0] count;
    logic          skip_lo;

    logic [15:0]   hw0, hw1;
    logic          is_rvc, valid_raw, xfer, push_en;
    logic [CW-1:0] pop_n, push_n, cnt_pop, count_nxt;
    logic [QW-1:0] push_ext, q_nxt;
    logic [31:0]   rd_pc;
    logic          unused_pc_bit0;

    assign unused_pc_bit0   = redirect_pc[0];
    assign rd_pc            = RVC_EN ? redirect_pc : {redirect_pc[31:2], 2'b00};
    assign mem_byte_address = fetch_ptr;

    assign hw0       = q[15:0];
    assign hw1       = q[31:16];
    assign is_rvc    = RVC_EN && (hw0[1:0] != 2'b11);
    assign valid_raw = is_rvc ? (count >= CW'(1)) : (count >= CW'(2));

    assign instr_valid      = valid_raw & ~redirect_valid;
    assign instr            = !valid_raw ? 32'h0 : (is_rvc ? {16'h0, hw0} : {hw1, hw0});
    assign instr_pc         = head_pc;
    assign instr_compressed = valid_raw & is_rvc;
    assign xfer             = instr_valid & instr_ready;

    // Pop shifts the head out; push appends behind whatever survives the pop.
    // Slots above count are kept zero so the append can simply OR in.
    always_comb begin
        pop_n = '0;
        if (xfer)
            pop_n = is_rvc ? CW'(1) : CW'(2);
        push_en  = (count <= CW'(BUF_HW - 2));
        push_n   = skip_lo ? CW'(1) : CW'(2);
        push_ext = skip_lo ? QW'({16'h0, mem_read_data[31:16]}) : QW'(mem_read_data);
        cnt_pop  = count - pop_n;
        q_nxt    = q >> (16 * int'(pop_n));
        count_nxt = cnt_pop;
        if (push_en) begin
            q_nxt     = q_nxt | (push_ext << (16 * int'(cnt_pop)));
            count_nxt = cnt_pop + push_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_ptr <= {RST_PC[31:2], 2'b00};
            head_pc   <= RST_PC;
            q         <= '0;
            count     <= '0;
            skip_lo   <= RST_PC[1];
        end else if (redirect_valid) begin
            fetch_ptr <= {rd_pc[31:2], 2'b00};
            head_pc   <= rd_pc;
            q         <= '0;
            count     <= '0;
            skip_lo   <= rd_pc[1];
        end else begin
            q     <= q_nxt;
            count <= count_nxt;
            if (push_en) begin
                fetch_ptr <= fetch_ptr + 32'd4;
                skip_lo   <= 1'b0;
            end
            if (xfer)
                head_pc <= head_pc + (is_rvc ? 32'd2 : 32'd4);
        end
    end
endmodule

// File: tb/tb_fetch_align_buffer.sv
// Scoreboard bench for fetch_align_buffer: directed program image, expected instructions queued by the driver.
module tb_fetch_align_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_byte_address, mem_read_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid, instr_ready, instr_compressed;
    logic [31:0] instr, instr_pc;

`ifdef FETCH_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        c;
    } exp_t;

    exp_t        sb_q[$];
    int          pending = 0;
    int          checks = 0;
    int          errors = 0;
    logic        ready_en = 1'b0;
    logic        ready_force = 1'b0;
    logic [31:0] mem [64];

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_byte_address[7:2]];
    assign instr_ready   = ready_force | (ready_en & (pending != 0));

    fetch_align_buffer #(.RESET_PC(32'h0), .BUF_HW(4)) dut (
        .clk(clk), .reset(rst),
        .mem_byte_address(mem_byte_address), .mem_read_data(mem_read_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .instr_compressed(instr_compressed)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_instr(input logic [31:0] ins, input logic [31:0] pc, input logic c);
        sb_q.push_back('{ins: ins, pc: pc, c: c});
        pending++;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (pending != 0 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        if (pending != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: %0d instructions never arrived, required 0", name, pending);
            sb_q.delete();
            pending = 0;
        end
    endtask

    // Sample on the falling edge, retire after the rising edge that performs the transfer.
    initial begin
        exp_t got, e;
        forever begin
            @(negedge clk);
            if (!rst && instr_valid && instr_ready) begin
                got = '{ins: instr, pc: instr_pc, c: instr_compressed};
                @(posedge clk); #1;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_instr: got %h pc %h c %0b, required none", got.ins, got.pc, got.c);
                end else begin
                    e = sb_q.pop_front();
                    pending--;
                    if (got !== e) begin
                        errors++;
                        $display("FAIL instr_stream: got %h pc %h c %0b, required %h pc %h c %0b",
                                 got.ins, got.pc, got.c, e.ins, e.pc, e.c);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit hit, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        mem[0] = 32'h0020_0093;
        mem[1] = 32'h0593_4529;
        mem[2] = 32'h061d_0050;
        for (int i = 3; i < 64; i++) mem[i] = 32'h0000_0013 | (i << 20);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_comp", {31'h0, instr_compressed}, 32'h0);
        chk("rst_addr", mem_byte_address, 32'h0);

        // First push
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("first_valid", {31'h0, instr_valid}, 32'h1);
        chk("first_instr", instr, 32'h0020_0093);
        chk("first_pc", instr_pc, 32'h0);
        chk("first_comp", {31'h0, instr_compressed}, 32'h0);

        // Stall: queue fills to 4 halfwords, fetch stops at 0x08
        repeat (6) @(posedge clk);
        #1;
        chk("stall_addr", mem_byte_address, 32'h8);
        chk("stall_instr", instr, 32'h0020_0093);
        @(posedge clk); #1;
        chk("stall_addr_hold", mem_byte_address, 32'h8);
        chk("stall_pc_hold", instr_pc, 32'h0);

        // Mixed stream
        expect_instr(32'h0020_0093, 32'h0, 1'b0);
`ifdef FETCH_RVC_EN
        expect_instr(32'h0000_4529, 32'h4, 1'b1);
        expect_instr(32'h0050_0593, 32'h6, 1'b0);
        expect_instr(32'h0000_061d, 32'hA, 1'b1);
`else
        expect_instr(32'h0593_4529, 32'h4, 1'b0);
        expect_instr(32'h061d_0050, 32'h8, 1'b0);
`endif
        expect_instr(32'h0030_0013, 32'hC, 1'b0);
        ready_en = 1'b1;
        drain("stream");

        // Redirect to 0x0A while decode is ready: no transfer, restart two cycles later
        ready_force    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_000A;
        @(negedge clk);
        chk("redir_forced_invalid", {31'h0, instr_valid}, 32'h0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        ready_force    = 1'b0;
        chk("redir_gap_invalid", {31'h0, instr_valid}, 32'h0);
`ifdef FETCH_RVC_EN
        expect_instr(32'h0000_061d, 32'hA, 1'b1);
`else
        expect_instr(32'h061d_0050, 32'h8, 1'b0);
`endif
        expect_instr(32'h0030_0013, 32'hC, 1'b0);
        @(posedge clk); #1;
        chk("redir_addr", mem_byte_address, 32'hC);
        chk("redir_valid", {31'h0, instr_valid}, 32'h1);
        chk("redir_pc", instr_pc, RVC ? 32'hA : 32'h8);
        drain("redir");

        // Back-to-back redirects: 0x10 is overridden by 0x20
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        @(posedge clk); #1;
        redirect_pc    = 32'h20;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        expect_instr(32'h0080_0013, 32'h20, 1'b0);
        expect_instr(32'h0090_0013, 32'h24, 1'b0);
        @(posedge clk); #1;
        chk("b2b_addr", mem_byte_address, 32'h24);
        drain("b2b");

        // Fetch and PC wrap past 0xFFFFFFFC
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        expect_instr(32'h03F0_0013, 32'hFFFF_FFFC, 1'b0);
        expect_instr(32'h0020_0093, 32'h0, 1'b0);
        drain("wrap");

        // Reset mid-operation drops queued data at once
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'h0, instr_valid}, 32'h0);
        chk("midrst_instr", instr, 32'h0);
        chk("midrst_pc", instr_pc, 32'h0);
        chk("midrst_addr", mem_byte_address, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rerun_valid", {31'h0, instr_valid}, 32'h1);
        chk("rerun_instr", instr, 32'h0020_0093);

        chk("sb_empty", pending, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
